// File: rtl/multi_stage_down_counter.sv
// Multi-stage minute/second cook timer: programmable stages run back to back on
// the 1 Hz clock, with pause/resume, cancel and a saturating quick-add/quick-start.
module multi_stage_down_counter #(
  parameter  int unsigned NUM_STAGES = 2,
  parameter  int unsigned MIN_W      = 6,
  parameter  int unsigned MAX_MIN    = 59,
  parameter  int unsigned ADD_SEC    = 30,
  localparam int unsigned IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        clk_1Hz,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_STAGES*MIN_W-1:0] load_minutes,
  input  logic [NUM_STAGES*6-1:0]     load_seconds,
  input  logic [NUM_STAGES-1:0]       stage_en,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        cancel,
  input  logic                        add_time,
  output logic [MIN_W-1:0]            minutes,
  output logic [5:0]                  seconds,
  output logic [IDX_W-1:0]            stage_idx,
  output logic                        running,
  output logic                        paused,
  output logic                        stage_done,
  output logic                        timerEnd
);

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MSUM_W = MIN_W + 1;
  localparam int unsigned CNT_W  = MIN_W + SEC_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               quick_q, quick_d;
  logic               stage_done_q, stage_done_d;
  logic               running_q, paused_q, timer_end_q;
  logic [MIN_W-1:0]   pmin_q [NUM_STAGES];
  logic [SEC_W-1:0]   psec_q [NUM_STAGES];
  logic [MIN_W-1:0]   ld_min [NUM_STAGES];
  logic [SEC_W-1:0]   ld_sec [NUM_STAGES];
  logic               first_found, next_found;
  logic [IDX_W-1:0]   first_idx, next_idx;
  logic [CNT_W-1:0]   add_run, add_pause;
  logic               cnt_zero;

  // Add n seconds to m:s, carrying into minutes and capping at MAX_MIN:59.
  function automatic logic [CNT_W-1:0] add_sat(input logic [MIN_W-1:0] m,
                                               input logic [SEC_W-1:0] s,
                                               input logic [SEC_W-1:0] n);
    logic [SEC_W:0]    ssum;
    logic [MSUM_W-1:0] msum;
    ssum = {1'b0, s} + {1'b0, n};
    msum = {1'b0, m};
    if (ssum >= 7'd60) begin
      ssum = ssum - 7'd60;
      msum = msum + MSUM_W'(1);
    end
    if (msum > MSUM_W'(MAX_MIN)) return {MIN_W'(MAX_MIN), 6'd59};
    return {msum[MIN_W-1:0], ssum[SEC_W-1:0]};
  endfunction

  // Load-time clamping of each packed preset field.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      ld_min[k] = (load_minutes[k*MIN_W +: MIN_W] > MIN_W'(MAX_MIN)) ?
                  MIN_W'(MAX_MIN) : load_minutes[k*MIN_W +: MIN_W];
      ld_sec[k] = (load_seconds[k*SEC_W +: SEC_W] > 6'd59) ?
                  6'd59 : load_seconds[k*SEC_W +: SEC_W];
    end
  end

  // Lowest enabled stage, and lowest enabled stage above the active one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_en[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (stage_en[i] && (IDX_W'(i) > idx_q)) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  assign cnt_zero  = (min_q == '0) && (sec_q == '0);
  assign add_run   = add_sat(min_q, sec_q, SEC_W'(ADD_SEC - 1));
  assign add_pause = add_sat(min_q, sec_q, SEC_W'(ADD_SEC));

  always_comb begin
    state_d      = state_q;
    min_d        = min_q;
    sec_d        = sec_q;
    idx_d        = idx_q;
    quick_d      = quick_q;
    stage_done_d = 1'b0;
    if (cancel) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
      idx_d   = '0;
      quick_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (first_found) begin
              state_d = S_RUN;
              idx_d   = first_idx;
              quick_d = 1'b0;
              min_d   = pmin_q[first_idx];
              sec_d   = psec_q[first_idx];
            end
          end else if (add_time) begin
            state_d = S_RUN;
            idx_d   = '0;
            quick_d = 1'b1;
            min_d   = '0;
            sec_d   = SEC_W'(ADD_SEC);
          end
        end
        S_RUN: begin
          // The extra second absorbed by add_time accounts for this edge's decrement.
          if (pause) begin
            state_d = S_PAUSED;
          end else if (add_time) begin
            if (cnt_zero) begin
              min_d = '0;
              sec_d = SEC_W'(ADD_SEC);
            end else begin
              {min_d, sec_d} = add_run;
            end
          end else if (!cnt_zero) begin
            if (sec_q == '0) begin
              sec_d = 6'd59;
              min_d = min_q - MIN_W'(1);
            end else begin
              sec_d = sec_q - SEC_W'(1);
            end
          end else if (next_found && !quick_q) begin
            idx_d        = next_idx;
            min_d        = pmin_q[next_idx];
            sec_d        = psec_q[next_idx];
            stage_done_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
        S_PAUSED: begin
          if (start) begin
            state_d = S_RUN;
          end else if (add_time) begin
            {min_d, sec_d} = add_pause;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      idx_q        <= '0;
      quick_q      <= 1'b0;
      stage_done_q <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      timer_end_q  <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        pmin_q[k] <= '0;
        psec_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      idx_q        <= idx_d;
      quick_q      <= quick_d;
      stage_done_q <= stage_done_d;
      running_q    <= (state_d == S_RUN);
      paused_q     <= (state_d == S_PAUSED);
      timer_end_q  <= (state_d == S_DONE);
      if ((state_q == S_IDLE) && load) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          pmin_q[k] <= ld_min[k];
          psec_q[k] <= ld_sec[k];
        end
      end
    end
  end

  // In IDLE the display previews the preset that a start would run first.
  assign minutes    = (state_q == S_IDLE) ? (first_found ? pmin_q[first_idx] : '0) : min_q;
  assign seconds    = (state_q == S_IDLE) ? (first_found ? psec_q[first_idx] : '0) : sec_q;
  assign stage_idx  = idx_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign stage_done = stage_done_q;
  assign timerEnd   = timer_end_q;

endmodule

// File: doc/multi_stage_down_counter.md
# multi_stage_down_counter

Parametrised successor to the single-stage microwave minute/second down counter. Runs up to NUM_STAGES programmed cook stages back to back (for example defrost, then cook) from the 1 Hz clock. Adds pause/resume, cancel, and a saturating "+ADD_SEC" quick-add/quick-start. Feeds the display driver with minutes/seconds and the controller with per-stage and end-of-cook indications.

## Interface
Parameters:
- NUM_STAGES, 2, number of programmable stages (1..8)
- MIN_W, 6, minutes field width
- MAX_MIN, 59, largest minutes value; must be < 2^MIN_W
- ADD_SEC, 30, seconds added per add_time (1..59)

Ports:
- clk_1Hz  in  1  counter clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- load  in  1  in IDLE, capture load_minutes/load_seconds into all stage preset registers
- load_minutes  in  NUM_STAGES*MIN_W  packed presets; stage k at [k*MIN_W +: MIN_W]
- load_seconds  in  NUM_STAGES*6  packed presets; stage k at [k*6 +: 6]
- stage_en  in  NUM_STAGES  stage k is run only if stage_en[k]=1
- start  in  1  start (IDLE/DONE) or resume (PAUSED)
- pause  in  1  RUN -> PAUSED
- cancel  in  1  abort to IDLE from any state
- add_time  in  1  add ADD_SEC to the current count, or quick-start from IDLE
- minutes  out  MIN_W  displayed minutes
- seconds  out  6  displayed seconds (0..59)
- stage_idx  out  clog2(NUM_STAGES) or 1 bit if NUM_STAGES=1  active stage
- running  out  1  state==RUN
- paused  out  1  state==PAUSED
- stage_done  out  1  one-cycle pulse when a non-final stage completes
- timerEnd  out  1  high throughout DONE

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset: IDLE, presets 0, count 0:00, stage_idx 0, quick flag 0, all outputs 0.
- Load clamping: seconds >59 store 59; minutes >MAX_MIN store MAX_MIN. load is ignored outside IDLE.
- IDLE display: preset of the lowest enabled stage; 0:00 if none enabled.
- Input priority each edge: cancel > start/pause > add_time.
- IDLE:
  - start with at least one stage enabled: count <= preset of lowest enabled stage, stage_idx <= that index, state RUN.
  - start with no stages enabled: ignored, remain IDLE.
  - add_time (start low): count <= 0:ADD_SEC, quick flag <= 1, state RUN. A quick run is a single final stage.
- RUN, each edge:
  - count > 0:00: decrement. Seconds 0 -> 59 with minutes -1; otherwise seconds -1.
  - count == 0:00: stage complete. Go to the next higher enabled stage: load its preset and pulse stage_done. If there is none, or the quick flag is set, go to DONE.
  - A zero-preset stage therefore occupies exactly one cycle at 0:00.
- add_time in RUN: count <= sat(count + ADD_SEC − 1) when count > 0; count <= 0:ADD_SEC with no stage advance when count == 0.
- add_time in PAUSED: count <= sat(count + ADD_SEC).
- sat: seconds sum ≥60 carries 1 into minutes with seconds −60; the result is capped at MAX_MIN:59.
- pause in RUN: freeze count, state PAUSED. start in PAUSED: state RUN, decrementing resumes next edge.
- DONE: count holds 0:00, timerEnd=1.
  - start: behaves as start from IDLE (fresh run from presets).
  - add_time: quick-start.
  - timerEnd drops on leaving DONE.
- cancel in any state: IDLE, quick flag 0, stage_idx 0, no pulses. Presets are retained.
- stage_en is sampled at each stage transition. Disabling the active stage mid-run does not abort it.

## Timing
- All outputs are registered except the IDLE preset display, which is a mux of registers.
- start at edge k: RUN after k. The first decrement occurs at edge k+1.
- A single stage of T seconds (T = 60·M + S) reaches 0:00 at edge k+T. DONE follows at edge k+T+1.
- stage_done is high for the one cycle after the transition edge, coincident with the new preset on minutes/seconds.
- Asynchronous reset mid-run: immediate IDLE and 0:00 on display. The first edge after deassertion behaves as IDLE.

## Test plan
- Single stage preset 1:02, start -> display 1:02, 1:01, 1:00, 0:59 … 0:00. timerEnd rises at edge 63 after start. running low in DONE.
- Two stages {0:03, 0:02}, both enabled -> 0:03…0:00, then 0:02 with stage_done=1 and stage_idx=1 for one cycle, then …0:00, then DONE at edge 7.
- stage_en=2'b10, start -> run begins with stage 1's preset. stage_en=0, start -> stays IDLE, display 0:00.
- Run at 2:10, pause for 5 edges -> count frozen at 2:10. start -> resumes 2:09.
- add_time at 59:50 while RUN -> 59:59 (saturated). add_time in IDLE -> RUN from 0:30, DONE after 31 edges regardless of presets.
- cancel at 0:05 of stage 0 -> IDLE, display shows stage 0 preset. Reset asserted mid-RUN -> all outputs 0 immediately.
